// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between the async FIFO and its UART consumer.
// fifo_empty/fifo_rdata come from the FIFO, fifo_rinc is the one-cycle pop strobe back.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rinc;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rinc
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rinc
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends each as a UART frame, one bit per clk.
// Ports: clk, rst_n (sync, active-low), fifo (master: empty/rdata in, rinc out),
//        par_en_i, par_typ_i (0 even / 1 odd), tx_out_o (idle high), busy_o.
module fifo_uart_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_uart_tx_if.master fifo,
  input  logic           par_en_i,
  input  logic           par_typ_i,
  output logic           tx_out_o,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               pen_q, pen_d;
  logic               pbit_q, pbit_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               rinc;

  assign fifo.fifo_rinc = rinc;
  assign tx_out_o       = tx_q;
  assign busy_o         = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pen_q   <= pen_d;
      pbit_q  <= pbit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    rinc    = (state_q == IDLE) && !fifo.fifo_empty && rst_n;
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pen_d   = pen_q;
    pbit_d  = pbit_q;

    unique case (state_q)
      IDLE: begin
        if (rinc) begin
          shift_d = fifo.fifo_rdata;
          pen_d   = par_en_i;
          pbit_d  = (^fifo.fifo_rdata) ^ par_typ_i;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST) begin
          state_d = pen_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  // In DATA the shift register moves before the bit is shown, hence shift_d[0].
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_d[0];
      PARITY:  tx_d   = pbit_q;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random and directed stimulus against a frame-level UART model.
// The FIFO is a tb queue; each pop expands into the expected start/data/parity/stop bits.
module tb_fifo_uart_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic tx, busy;

  fifo_uart_tx_if #(.WIDTH(W)) ifc ();

  fifo_uart_tx #(.WIDTH(W), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fifo     (ifc.master),
    .par_en_i (par_en),
    .par_typ_i(par_typ),
    .tx_out_o (tx),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] q[$];
  logic [W-1:0] sent[$];
  logic [W-1:0] w;
  bit exp_bits[$];
  bit obs[$];
  bit ef[$];
  int pops[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  // FIFO model drives empty/rdata just after each edge.
  initial begin
    ifc.fifo_empty = 1'b1;
    ifc.fifo_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      ifc.fifo_empty = (q.size() == 0);
      ifc.fifo_rdata = (q.size() != 0) ? q[0] : W'($urandom);
    end
  end

  // Frame-level scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (exp_bits.size() != 0) begin
        chk("tx_bit", 32'(tx), 32'(exp_bits.pop_front()));
        chk("busy_frame", 32'(busy), 1);
        chk("rinc_frame", 32'(ifc.fifo_rinc), 0);
      end else begin
        chk("tx_idle", 32'(tx), 1);
        chk("busy_idle", 32'(busy), 0);
        chk("rinc_idle", 32'(ifc.fifo_rinc),
            32'(rst_n && q.size() != 0));
        if (rst_n && q.size() != 0) begin
          w = q.pop_front();
          sent.push_back(w);
          pops.push_back(cyc);
          exp_bits.push_back(1'b0);
          for (int i = 0; i < W; i++) exp_bits.push_back(w[i]);
          if (par_en) exp_bits.push_back((^w) ^ par_typ);
          exp_bits.push_back(1'b1);
        end
      end
      if (busy === 1'b1) obs.push_back(tx);
      if (!rst_n) exp_bits.delete();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || exp_bits.size() != 0) && n < 200) begin
      step(1);
      n++;
    end
    step(2);
    chk("drain_timeout", 32'(n < 200), 1);
  endtask

  task automatic wait_pop(input int k);
    int n = 0;
    while (pops.size() < k && n < 50) begin
      step(1);
      n++;
    end
    chk("pop_timeout", 32'(n < 50), 1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, 32'(obs.size()), 32'(ef.size()));
    for (int i = 0; i < ef.size(); i++) begin
      if (i < obs.size()) chk(tag, 32'(obs[i]), 32'(ef[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rinc", 32'(ifc.fifo_rinc), 0);
    mon_en = 1'b1;
    rst_n = 1'b1;

    step(20);
    chk("idle_pops", 32'(pops.size()), 0);

    obs.delete();
    par_en = 1'b0;
    q.push_back(8'hA5);
    drain();
    ef = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    cmp_frame("a5");

    obs.delete();
    par_en = 1'b1;
    par_typ = 1'b0;
    q.push_back(8'h03);
    drain();
    ef = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    cmp_frame("03_even");

    obs.delete();
    par_typ = 1'b1;
    q.push_back(8'h03);
    drain();
    ef = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    cmp_frame("03_odd");

    pops.delete();
    sent.delete();
    par_en = 1'b0;
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    drain();
    chk("b2b_pops", 32'(pops.size()), 3);
    if (pops.size() == 3) begin
      chk("b2b_gap0", 32'(pops[1] - pops[0]), 11);
      chk("b2b_gap1", 32'(pops[2] - pops[1]), 11);
      chk("b2b_w0", 32'(sent[0]), 32'h11);
      chk("b2b_w1", 32'(sent[1]), 32'h22);
      chk("b2b_w2", 32'(sent[2]), 32'h33);
    end

    pops.delete();
    sent.delete();
    q.push_back(8'hFF);
    q.push_back(8'h5A);
    wait_pop(1);
    step(5);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    obs.delete();
    drain();
    ef = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    cmp_frame("5a");
    chk("mid_rst_pops", 32'(sent.size()), 2);
    if (sent.size() == 2) chk("mid_rst_w1", 32'(sent[1]), 32'h5A);

    obs.delete();
    pops.delete();
    par_en = 1'b0;
    q.push_back(8'h3C);
    wait_pop(1);
    step(4);
    par_en = 1'b1;
    par_typ = 1'b1;
    drain();
    chk("pen_mid_len", 32'(obs.size()), 10);
    obs.delete();
    q.push_back(8'h3C);
    drain();
    chk("pen_next_len", 32'(obs.size()), 11);
    if (obs.size() == 11) chk("pen_next_par", 32'(obs[9]), 1);

    sent.delete();
    for (int i = 0; i < 600; i++) begin
      step(1);
      if ($urandom_range(0, 3) == 0 && q.size() < 6)
        q.push_back(W'($urandom));
      par_en = 1'($urandom);
      par_typ = 1'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    rst_n = 1'b1;
    drain();
    chk("rand_q_empty", 32'(q.size()), 0);
    chk("rand_sent_some", 32'(sent.size() > 10), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the async FIFO. Runs in the FIFO read clock domain.
- Pops one word whenever the FIFO is non-empty and serializes it as a UART frame: start bit, data LSB-first, optional parity bit, one stop bit.
- Drives the FIFO read-increment strobe directly.
- Exposes a busy flag to the system controller.

Parameters:
- WIDTH, 8, data word width; must match the FIFO data width.
- CNT_W, 3, width of the data-bit counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  bit clock; one serial bit per cycle (the FIFO read clock).
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- fifo_empty  input  1  FIFO rempty flag.
- fifo_rdata  input  WIDTH  FIFO rdata; valid whenever fifo_empty=0.
- par_en  input  1  1 = parity bit included in frame.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- fifo_rinc  output  1  one-cycle pop strobe to the FIFO (rinc).
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while a frame (start through stop) is being sent.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates on the rising edge of clk.
- Reset values (rst_n=0 at an edge):
  - state = IDLE, tx_out = 1, busy = 0, counter = 0, shift register = 0.
  - fifo_rinc is forced to 0 while rst_n=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out = 1, busy = 0.
  - fifo_rinc = (state==IDLE) && !fifo_empty && rst_n. This is combinational and lasts exactly one cycle per pop.
  - On the edge ending a cycle with fifo_rinc=1:
    - latch fifo_rdata into the shift register;
    - latch par_en and par_typ into frame-local registers;
    - compute parity bit = ^fifo_rdata XOR par_typ;
    - go to START.
- START: tx_out = 0, busy = 1, lasts 1 cycle, then go to DATA with counter = 0.
- DATA:
  - tx_out = shift register bit 0; shift right each cycle; counter increments.
  - After WIDTH cycles (counter == WIDTH-1), go to PARITY if the latched par_en=1, else go to STOP.
- PARITY: tx_out = latched parity bit, 1 cycle, then go to STOP.
- STOP: tx_out = 1, busy = 1, 1 cycle, then go to IDLE.
- tx_out and busy are registered. The values above are those visible during the cycle spent in each state.
- Latency: the start bit appears on the cycle immediately after the fifo_rinc cycle.
- Frame length, pop cycle to end of stop:
  - 2+WIDTH+1 = 11 cycles with parity off;
  - 12 cycles with parity on (WIDTH=8).
- Back-to-back: after STOP there is always exactly one IDLE cycle (line high). The next pop can occur in that IDLE cycle, so the minimum inter-frame idle is 1 cycle.
- fifo_empty and fifo_rdata are ignored outside IDLE. Exactly one pop per frame, never two.
- par_en and par_typ changes mid-frame have no effect on the current frame.
- FIFO goes non-empty during a frame: the word waits until the next IDLE cycle. No loss, no duplicate.
- Reset mid-frame (rst_n=0 at any edge):
  - go to IDLE immediately, tx_out=1 on the next cycle;
  - the partially sent word is discarded and not re-popped.
- fifo_empty=0 during reset: no pop. The first pop is in the first cycle with rst_n=1.

Test Plan:
- Reset, then fifo_empty=1 for 20 cycles -> tx_out=1, busy=0, fifo_rinc=0 throughout.
- fifo_rdata=0xA5, par_en=0, single word -> fifo_rinc high for exactly 1 cycle, then tx_out sequence 0,1,0,1,0,0,1,0,1,1, then IDLE. busy high for 10 cycles.
- fifo_rdata=0x03, par_en=1, par_typ=0 (even) -> data bits 1,1,0,0,0,0,0,0, parity bit 0, then stop 1.
- Repeat with par_typ=1 (odd) -> parity bit 1.
- Three words (0x11, 0x22, 0x33) queued with fifo_empty held low, par_en=0 -> exactly 3 pop strobes spaced 11 cycles apart, one idle-high cycle between frames, bytes sent in order.
- Reset asserted during DATA bit 4 of 0xFF -> tx_out=1 and busy=0 after the reset edge. After release with FIFO still holding 0x5A, the next frame carries 0x5A, not the remainder of 0xFF.
- par_en toggled 0→1 during DATA of a par_en=0 frame -> no parity bit in that frame. The next frame includes parity.
